// File: rtl/chunk_serialize_param_pkg.sv
// Shared definitions for the chunk serializer/deserializer pair.
//   CHUNK_BYTES : default pixel chunk width in bytes
//   chunk_t     : one default-width pixel chunk
//   beats()     : number of narrow beats a chunk splits into
//   state_t     : serializer control state
package chunk_serialize_param_pkg;

    localparam int CHUNK_BYTES = 4;

    typedef logic [8*CHUNK_BYTES-1:0] chunk_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    function automatic int beats(input int in_b, input int out_b);
        return in_b / out_b;
    endfunction

endpackage

// File: rtl/chunk_serialize_param.sv
// chunk_serialize_param
//   Splits one IN_BYTES-wide AXI-Stream chunk into IN_BYTES/OUT_BYTES narrow beats,
//   LSB lane first (MSB_FIRST=0) or MSB lane first (MSB_FIRST=1). A shift register
//   holds the chunk being sent and a hold register takes the next chunk, so back-to-back
//   chunks leave as a contiguous beat stream with no bubble.
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   axis_i_data  in   IN_BYTES*8 chunk data
//   axis_i_vld   in   chunk valid
//   axis_i_rdy   out  chunk ready (registered, depends only on hold-register state)
//   axis_i_last  in   chunk last flag (read only with CHUNK_SERIALIZE_LAST_EN)
//   axis_o_data  out  OUT_BYTES*8 beat data (driven straight from the shift register)
//   axis_o_vld   out  beat valid
//   axis_o_rdy   in   beat ready
//   axis_o_last  out  beat last (0 unless CHUNK_SERIALIZE_LAST_EN)
// Configuration macro: CHUNK_SERIALIZE_LAST_EN - carry last through SR/HR and flag the
//   final beat of a last chunk. Undefined: no last storage, axis_o_last tied low.
module chunk_serialize_param
    import chunk_serialize_param_pkg::*;
#(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_BYTES*8-1:0]  axis_i_data,
    input  logic                   axis_i_vld,
    output logic                   axis_i_rdy,
    input  logic                   axis_i_last,
    output logic [OUT_BYTES*8-1:0] axis_o_data,
    output logic                   axis_o_vld,
    input  logic                   axis_o_rdy,
    output logic                   axis_o_last
);

    localparam int BEATS = beats(IN_BYTES, OUT_BYTES);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IN_W  = IN_BYTES * 8;
    localparam int OUT_W = OUT_BYTES * 8;

    generate
        if ((IN_BYTES % OUT_BYTES) != 0 ||
            !(OUT_BYTES == 1 || OUT_BYTES == 2 || OUT_BYTES == 4)) begin : g_bad_cfg
            $error("chunk_serialize_param: IN_BYTES must be a multiple of OUT_BYTES (1, 2 or 4)");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [IN_W-1:0] sr_q, hr_q, sr_shifted;
    logic            hr_full_q, hr_full_d;
    logic [IW-1:0]   idx_q;
    logic            rdy_q;

    logic in_hs, out_hs, last_beat;
    logic sr_load_in, sr_load_hr, sr_shift, hr_cap;

    assign in_hs     = axis_i_vld && rdy_q;
    assign out_hs    = axis_o_vld && axis_o_rdy;
    assign last_beat = (idx_q == IW'(BEATS - 1));

    // The outgoing lane is fixed; the register shifts the next lane into it.
    generate
        if (MSB_FIRST) begin : g_msb
            assign axis_o_data = sr_q[IN_W-1 -: OUT_W];
            assign sr_shifted  = sr_q << OUT_W;
        end else begin : g_lsb
            assign axis_o_data = sr_q[OUT_W-1:0];
            assign sr_shifted  = sr_q >> OUT_W;
        end
    endgenerate

    // Datapath control. HR is drained before a fresh input may go straight to SR;
    // an input that is not consumed by SR this cycle lands in HR.
    always_comb begin
        sr_load_hr = out_hs && last_beat && hr_full_q;
        sr_load_in = in_hs && ((state_q == S_IDLE) || (out_hs && last_beat && !hr_full_q));
        sr_shift   = out_hs && !last_beat;
        hr_cap     = in_hs && !sr_load_in;
        hr_full_d  = hr_cap ? 1'b1 : (sr_load_hr ? 1'b0 : hr_full_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_hs) state_d = S_SEND;
            S_SEND: if (out_hs && last_beat && !hr_full_q && !in_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q      <= '0;
            hr_q      <= '0;
            hr_full_q <= 1'b0;
            idx_q     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            // Ready is a flop so it stays low through reset and has no path from axis_o_rdy.
            rdy_q     <= !hr_full_d;
            hr_full_q <= hr_full_d;
            if (hr_cap) hr_q <= axis_i_data;
            if (sr_load_hr)      sr_q <= hr_q;
            else if (sr_load_in) sr_q <= axis_i_data;
            else if (sr_shift)   sr_q <= sr_shifted;
            if (out_hs && last_beat)  idx_q <= '0;
            else if (sr_shift)        idx_q <= idx_q + IW'(1);
            else if (sr_load_in)      idx_q <= '0;
        end
    end

`ifdef CHUNK_SERIALIZE_LAST_EN
    logic sr_last_q, hr_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_last_q <= 1'b0;
            hr_last_q <= 1'b0;
        end else begin
            if (hr_cap) hr_last_q <= axis_i_last;
            if (sr_load_hr)      sr_last_q <= hr_last_q;
            else if (sr_load_in) sr_last_q <= axis_i_last;
        end
    end

    // Output logic
    always_comb begin
        axis_o_vld  = (state_q == S_SEND);
        axis_o_last = (state_q == S_SEND) && last_beat && sr_last_q;
    end
`else
    logic unused_last;
    assign unused_last = axis_i_last;

    // Output logic
    always_comb begin
        axis_o_vld  = (state_q == S_SEND);
        axis_o_last = 1'b0;
    end
`endif

    assign axis_i_rdy = rdy_q;

endmodule

// File: tb/tb_chunk_serialize_param.sv
module tb_chunk_serialize_param;

`ifdef CHUNK_SERIALIZE_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 -> 1 byte, LSB lane first
    logic [31:0] a_idata = '0;
    logic        a_ivld = 1'b0, a_ilast = 1'b0, a_irdy;
    logic [7:0]  a_odata;
    logic        a_ovld, a_olast, a_ordy = 1'b1;

    // DUT B: 4 -> 2 bytes, MSB lane first
    logic [31:0] b_idata = '0;
    logic        b_ivld = 1'b0, b_ilast = 1'b0, b_irdy;
    logic [15:0] b_odata;
    logic        b_ovld, b_olast, b_ordy = 1'b1;

    chunk_serialize_param #(.IN_BYTES(4), .OUT_BYTES(1), .MSB_FIRST(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .axis_i_data(a_idata), .axis_i_vld(a_ivld), .axis_i_rdy(a_irdy), .axis_i_last(a_ilast),
        .axis_o_data(a_odata), .axis_o_vld(a_ovld), .axis_o_rdy(a_ordy), .axis_o_last(a_olast)
    );

    chunk_serialize_param #(.IN_BYTES(4), .OUT_BYTES(2), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst(rst),
        .axis_i_data(b_idata), .axis_i_vld(b_ivld), .axis_i_rdy(b_irdy), .axis_i_last(b_ilast),
        .axis_o_data(b_odata), .axis_o_vld(b_ovld), .axis_o_rdy(b_ordy), .axis_o_last(b_olast)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted chunk becomes a queue of expected beats; outputs must present
    // the queue head the cycle after acceptance and keep it until it is taken.
    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    logic [8:0]  loga[$];   // {last, data} of each beat taken from DUT A
    logic [15:0] logb[$];
    logic        rel;

    always @(posedge clk or negedge rst) begin
        if (!rst) rel <= 1'b0;
        else      rel <= 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_rst_vld",  a_ovld,  0);
            chk("a_rst_data", a_odata, 0);
            chk("a_rst_last", a_olast, 0);
            chk("a_rst_rdy",  a_irdy,  0);
            qa.delete();
        end else begin
            // Hold register is occupied exactly when more than one chunk's beats are pending.
            chk("a_rdy", a_irdy, rel && (qa.size() <= 4));
            chk("a_vld", a_ovld, qa.size() > 0);
            if (a_ovld && qa.size() > 0) begin
                chk("a_data", a_odata, qa[0].d);
                chk("a_last", a_olast, qa[0].l);
                if (a_ordy) begin
                    loga.push_back({a_olast, a_odata});
                    void'(qa.pop_front());
                end
            end
            if (a_ivld && a_irdy)
                for (int j = 0; j < 4; j++)
                    qa.push_back('{d: 16'((a_idata >> (8*j)) & 32'hFF),
                                   l: LAST_EN && a_ilast && (j == 3)});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("b_rst_vld",  b_ovld,  0);
            chk("b_rst_data", b_odata, 0);
            qb.delete();
        end else begin
            chk("b_rdy", b_irdy, rel && (qb.size() <= 2));
            chk("b_vld", b_ovld, qb.size() > 0);
            chk("b_last", b_olast, 0);
            if (b_ovld && qb.size() > 0) begin
                chk("b_data", b_odata, qb[0].d);
                if (b_ordy) begin
                    logb.push_back(b_odata);
                    void'(qb.pop_front());
                end
            end
            if (b_ivld && b_irdy)
                for (int j = 0; j < 2; j++)
                    qb.push_back('{d: 16'(b_idata >> (16*(1-j))), l: 1'b0});
        end
    end

    task automatic send_a(input logic [31:0] d, input logic l, output int waited);
        a_idata = d;
        a_ilast = l;
        a_ivld  = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!a_irdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("a_accept_timeout", waited >= 100, 0);
        @(posedge clk); #1;
        a_ivld = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d);
        int k = 0;
        b_idata = d;
        b_ivld  = 1'b1;
        @(negedge clk);
        while (!b_irdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b_accept_timeout", k >= 100, 0);
        @(posedge clk); #1;
        b_ivld = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((a_ovld || b_ovld || qa.size() > 0 || qb.size() > 0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, k >= 200, 0);
    endtask

    // Literal check of the bytes taken from DUT A; beat i expected in exp[8*i +: 8].
    task automatic chk_log_a(input string nm, input int n, input logic [63:0] exp);
        chk({nm, "_count"}, loga.size(), n);
        for (int i = 0; i < n; i++)
            if (i < loga.size()) chk(nm, loga[i][7:0], exp[8*i +: 8]);
    endtask

    initial begin
        int w;
        logic [9:0] pat;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: single chunk, LSB first
        loga.delete();
        send_a(32'h44332211, 1'b0, w);
        drain("t1_drain");
        chk_log_a("t1_bytes", 4, 64'h44332211);

        // 2: back-to-back chunks, second accepted without a wait
        loga.delete();
        send_a(32'h44332211, 1'b0, w);
        send_a(32'h88776655, 1'b0, w);
        chk("t2_no_stall", w, 0);
        drain("t2_drain");
        chk_log_a("t2_bytes", 8, 64'h8877665544332211);

        // 3: output back-pressure 1,0,0,1,0,1,0,1,1,1
        loga.delete();
        pat = 10'b1110101001;   // bit i applies to cycle i after acceptance
        send_a(32'hDDCCBBAA, 1'b0, w);
        for (int i = 0; i < 10; i++) begin
            a_ordy = pat[i];
            @(posedge clk); #1;
        end
        a_ordy = 1'b1;
        drain("t3_drain");
        chk_log_a("t3_bytes", 4, 64'hDDCCBBAA);

        // 4: half-word beats, MSB lane first
        logb.delete();
        send_b(32'hAABBCCDD);
        drain("t4_drain");
        chk("t4_count", logb.size(), 2);
        if (logb.size() == 2) begin
            chk("t4_beat0", logb[0], 16'hAABB);
            chk("t4_beat1", logb[1], 16'hCCDD);
        end

        // 5: reset mid-chunk with the hold register full, then a fresh chunk
        send_a(32'h44332211, 1'b0, w);
        send_a(32'h88776655, 1'b0, w);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_vld_in_rst", a_ovld, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        loga.delete();
        send_a(32'h0D0C0B0A, 1'b0, w);
        drain("t5_drain");
        chk_log_a("t5_bytes", 4, 64'h0D0C0B0A);

        // 6: last flag travels with the chunk and marks only its final beat
        loga.delete();
        send_a(32'h44332211, 1'b0, w);
        send_a(32'h88776655, 1'b1, w);
        drain("t6_drain");
        chk_log_a("t6_bytes", 8, 64'h8877665544332211);
        for (int i = 0; i < 8; i++)
            if (i < loga.size()) chk("t6_last", loga[i][8], LAST_EN && (i == 7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
